// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port
// share one fixed-latency memory port. One access is in flight at a time.
//
// Handshake (both requester ports): the requester raises *_req with its
// address/data stable and holds it until the one-cycle *_ack pulse. The ack
// cycle also presents the read data, which then holds until the next
// completion of the same kind. A request that is not being acked in the
// current cycle shows up on stall.
module mem_arbiter #(
   parameter int LATENCY = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // BUSY lasts LATENCY cycles: the counter runs LATENCY-1 down to 0.
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t        r_state;
   state_t        w_next_state;
   logic [3:0]    r_cnt;
   logic          r_rr_dm;     // 1: data port wins the next tie
   logic          r_gnt_dm;    // owner of the access in flight
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_dm_rdata;
   logic          w_grant;
   logic          w_pick_dm;
   logic          w_last;
   logic          w_busy;
   logic          w_resp;

   assign w_last = (r_cnt == 4'd0);
   assign w_busy = (r_state == ST_BUSY);
   assign w_resp = (r_state == ST_RESP);

   // Next-state decode and grant selection (round-robin on ties).
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_pick_dm    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               w_grant      = 1'b1;
               w_pick_dm    = dm_req && (!if_req || r_rr_dm);
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_last) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Grant latching, latency countdown and read-data capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         r_rr_dm    <= 1'b1;
         r_gnt_dm   <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else if (w_grant) begin
         r_gnt_dm <= w_pick_dm;
         r_rr_dm  <= !w_pick_dm;
         r_cnt    <= CNT_INIT;
         r_addr   <= w_pick_dm ? dm_addr : if_addr;
         r_we     <= w_pick_dm && dm_we;
         r_wdata  <= w_pick_dm ? dm_wdata : '0;
      end else if (w_busy) begin
         if (w_last) begin
            // Stores leave the load-data register untouched.
            if (!r_gnt_dm) begin
               r_if_rdata <= mem_rdata;
            end else if (!r_we) begin
               r_dm_rdata <= mem_rdata;
            end
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // Memory port is driven only during BUSY, zero otherwise.
   assign mem_en      = w_busy;
   assign mem_we      = w_busy && r_we;
   assign mem_addr    = w_busy ? r_addr : '0;
   assign mem_wdata   = w_busy ? r_wdata : '0;

   assign if_ack      = w_resp && !r_gnt_dm;
   assign dm_ack      = w_resp && r_gnt_dm;
   assign if_rdata    = r_if_rdata;
   assign dm_rdata    = r_dm_rdata;
   assign stall       = reset && ((if_req && !if_ack) || (dm_req && !dm_ack));
   assign o_dbg_state = r_state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, memory read/write latency in cycles (legal range 1..15).
REQ-002 Parameter: AW, default 32, address width.
REQ-003 Parameter: DW, default 32, data width.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-007 if_addr  in  AW  fetch address, stable while if_req high.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  out  DW  fetched word, valid with if_ack, held until next fetch completion.
REQ-010 dm_req  in  1  data-memory request, held until dm_ack.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  AW  data address, stable while dm_req high.
REQ-013 dm_wdata  in  DW  store data, stable while dm_req high.
REQ-014 dm_ack  out  1  one-cycle data completion pulse.
REQ-015 dm_rdata  out  DW  load data, valid with dm_ack, held until next load completion.
REQ-016 mem_en  out  1  memory port enable.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  AW  memory address.
REQ-019 mem_wdata  out  DW  memory write data.
REQ-020 mem_rdata  in  DW  memory read data, valid in the last BUSY cycle.
REQ-021 stall  out  1  high whenever if_req or dm_req is high and its ack is not asserted this cycle.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY, RESP; all outputs SHALL be registered or decoded from registered state.
REQ-023 In IDLE with any request high, the arbiter SHALL grant one requester, latch its addr/we/wdata into internal registers, load cnt = LATENCY-1, and enter BUSY next cycle.
REQ-024 If only one requester is high, it SHALL be granted; if both are high, grant SHALL go to the requester not granted last (round-robin pointer), updated on every grant.
REQ-025 In BUSY, mem_en SHALL be 1; mem_addr/mem_wdata SHALL be the latched values; mem_we SHALL be the latched dm_we for data grants and 0 for fetch grants.
REQ-026 In BUSY, cnt SHALL decrement each cycle; when cnt = 0, mem_rdata SHALL be captured into if_rdata (fetch) or dm_rdata (load), and the FSM SHALL enter RESP.
REQ-027 Stores SHALL NOT update dm_rdata.
REQ-028 In RESP, exactly the granted requester's ack SHALL be 1 for one cycle, mem_en SHALL be 0, and the FSM SHALL return to IDLE.
REQ-029 Requests seen in BUSY or RESP SHALL NOT be granted until the next IDLE cycle; the non-granted request SHALL remain pending, never dropped.
REQ-030 Latency: request sampled in IDLE at cycle t SHALL produce ack at cycle t+LATENCY+1; the minimum turnaround between grants is LATENCY+2 cycles.
REQ-031 mem_en, mem_we, mem_addr, and mem_wdata SHALL be 0 outside BUSY.
REQ-032 Request deassertion during BUSY or RESP (protocol violation) SHALL NOT abort the access; ack SHALL still be issued.

Reset
REQ-033 On a clk edge with reset = 0, the arbiter SHALL enter IDLE, clear cnt, and set the round-robin pointer to favour dm.
REQ-034 Reset SHALL force if_ack, dm_ack, mem_en, mem_we, and stall to 0, and force if_rdata, dm_rdata, mem_addr, and mem_wdata to 0.
REQ-035 Reset asserted in BUSY or RESP SHALL abort the access with no ack and no rdata update; the first grant after reset is evaluated in the first IDLE cycle with reset = 1.

Verification
REQ-036 LATENCY=2; if_req, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en for 2 cycles at 0x10, if_ack at t+3, if_rdata=0xDEADBEEF.
REQ-037 if_req and dm_req (load 0x200) rise together after reset -> dm is granted first and dm_ack is issued at t+3; the fetch is granted at t+4 and if_ack is issued at t+7.
REQ-038 Continuous if_req and dm_req for 4 transactions -> grants alternate dm, if, dm, if, with no requester starved.
REQ-039 Store dm_we=1, dm_addr=0x40, dm_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 for LATENCY cycles; dm_ack is issued; dm_rdata is unchanged.
REQ-040 reset=0 in the 2nd BUSY cycle of a fetch -> no if_ack; all outputs are 0 next cycle; a pending if_req is regranted after reset release.
REQ-041 LATENCY=1 build; single load -> exactly 1 mem_en cycle, dm_ack at t+2.
